// File: rtl/mdu_mul_pipe_if.sv
// Request/response bundle for the pipelined multiplier. The master side issues
// ops and consumes results; the slave side is the multiplier itself.
interface mdu_mul_pipe_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6
);
  logic              flush;
  logic              valid_i;
  logic              ready_o;
  logic [1:0]        op_i;
  logic [DATA_W-1:0] a_i;
  logic [DATA_W-1:0] b_i;
  logic [TAG_W-1:0]  tag_i;
  logic              valid_o;
  logic              ready_i;
  logic [DATA_W-1:0] data_o;
  logic [TAG_W-1:0]  tag_o;

  modport master (
    output flush, valid_i, op_i, a_i, b_i, tag_i, ready_i,
    input  ready_o, valid_o, data_o, tag_o
  );

  modport slave (
    input  flush, valid_i, op_i, a_i, b_i, tag_i, ready_i,
    output ready_o, valid_o, data_o, tag_o
  );
endinterface

// File: rtl/mdu_mul_pipe.sv
// LAT-stage pipelined RISC-V style multiplier (MUL/MULH/MULHU/MULHSU) with
// per-stage valid bits, collapsing bubbles, output back-pressure and flush.
module mdu_mul_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6,
  parameter int LAT    = 3
) (
  input  logic           clk,
  input  logic           rst,
  mdu_mul_pipe_if.slave  bus
);
  localparam logic [1:0] OP_MUL   = 2'd0;
  localparam logic [1:0] OP_MULH  = 2'd1;
  localparam logic [1:0] OP_MULHU = 2'd2;

  if (LAT < 2 || LAT > 6) begin : g_lat_chk
    $error("mdu_mul_pipe: LAT must be in 2..6");
  end

  logic [LAT:1]                vld_pipe;
  logic [LAT:0]                move;
  logic [1:0]                  op_q   [1:LAT];
  logic [TAG_W-1:0]            tag_q  [1:LAT];
  logic [2*DATA_W-1:0]         prod_q [2:LAT];
  logic signed [DATA_W:0]      a_q, b_q;
  logic signed [2*DATA_W+1:0]  prod_full;
  logic                        sx_a, sx_b;
  logic                        unused_prod;

  // move[k]: stage k can hand its content on, i.e. some later stage is
  // empty or the consumer takes the head. Unrolled form of the ripple chain.
  assign move[LAT] = bus.ready_i;
  for (genvar k = 0; k < LAT; k++) begin : g_move
    assign move[k] = bus.ready_i | ~(&vld_pipe[LAT:k+1]);
  end

  assign bus.ready_o = move[0] & ~bus.flush & ~rst;

  assign sx_a = (bus.op_i != OP_MULHU);
  assign sx_b = (bus.op_i == OP_MUL) | (bus.op_i == OP_MULH);

  assign prod_full   = a_q * b_q;
  assign unused_prod = ^prod_full[2*DATA_W+1:2*DATA_W];

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      vld_pipe <= '0;
    end else begin
      if (move[0]) vld_pipe[1] <= bus.valid_i;
      for (int k = 2; k <= LAT; k++)
        if (move[k-1]) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  // Datapath carries no reset; validity is tracked solely by vld_pipe.
  always_ff @(posedge clk) begin
    if (move[0]) begin
      a_q      <= {sx_a & bus.a_i[DATA_W-1], bus.a_i};
      b_q      <= {sx_b & bus.b_i[DATA_W-1], bus.b_i};
      op_q[1]  <= bus.op_i;
      tag_q[1] <= bus.tag_i;
    end
    if (move[1]) begin
      prod_q[2] <= prod_full[2*DATA_W-1:0];
      op_q[2]   <= op_q[1];
      tag_q[2]  <= tag_q[1];
    end
    for (int k = 3; k <= LAT; k++) begin
      if (move[k-1]) begin
        prod_q[k] <= prod_q[k-1];
        op_q[k]   <= op_q[k-1];
        tag_q[k]  <= tag_q[k-1];
      end
    end
  end

  assign bus.valid_o = vld_pipe[LAT];
  assign bus.data_o  = !vld_pipe[LAT]       ? '0 :
                       (op_q[LAT] == OP_MUL) ? prod_q[LAT][DATA_W-1:0]
                                             : prod_q[LAT][2*DATA_W-1:DATA_W];
  assign bus.tag_o   = vld_pipe[LAT] ? tag_q[LAT] : '0;
endmodule

// File: tb/tb_mdu_mul_pipe.sv
// Self-checking bench for mdu_mul_pipe: table vectors plus hand sequences for
// latency, streaming, stall, flush and reset, checked by a result scoreboard.
module tb_mdu_mul_pipe;
  localparam int DW  = 32;
  localparam int TW  = 6;
  localparam int LAT = 3;
  localparam logic [1:0] MUL = 2'd0, MULH = 2'd1, MULHU = 2'd2, MULHSU = 2'd3;

  typedef struct packed { logic [DW-1:0] d; logic [TW-1:0] t; } exp_t;
  typedef struct { logic [1:0] op; logic [DW-1:0] a, b; logic [TW-1:0] tag; logic [DW-1:0] exp; } vec_t;

  logic clk, rst;
  mdu_mul_pipe_if #(.DATA_W(DW), .TAG_W(TW)) bus ();
  mdu_mul_pipe #(.DATA_W(DW), .TAG_W(TW), .LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk = 0, n_pass = 0;
  int   cyc = 0, pops = 0;
  exp_t exp_q[$];
  int   pop_cyc[$];
  logic hold_pend = 1'b0;
  logic [DW-1:0] hold_d;
  logic [TW-1:0] hold_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) $display("FAIL %s: got %0h expected %0h", nm, act, req);
    else n_pass++;
  endtask

  function automatic logic [DW-1:0] model(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == MULHU) ? {32'b0, a} : {{32{a[31]}}, a};
    eb = (op == MUL || op == MULH) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (op == MUL) ? p[31:0] : p[63:32];
  endfunction

  // Scoreboard / protocol monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst || bus.flush) begin
      exp_q.delete();
    end else if (bus.valid_o && bus.ready_i) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_out: got tag %0h data %0h expected no result", bus.tag_o, bus.data_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_data", bus.data_o, e.d);
        chk("sb_tag", bus.tag_o, e.t);
      end
      pops++;
      pop_cyc.push_back(cyc);
    end
    if (!bus.valid_o) chk("idle_zero", {bus.data_o, bus.tag_o}, 0);
    if (hold_pend && !rst && !bus.flush)
      chk("hold_stable", {bus.valid_o, bus.data_o, bus.tag_o}, {1'b1, hold_d, hold_t});
    hold_pend = bus.valid_o && !bus.ready_i && !bus.flush && !rst;
    hold_d    = bus.data_o;
    hold_t    = bus.tag_o;
    cyc++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [TW-1:0] tag, input logic [DW-1:0] exp, output int waits);
    bus.valid_i = 1'b1; bus.op_i = op; bus.a_i = a; bus.b_i = b; bus.tag_i = tag;
    waits = 0;
    @(negedge clk);
    while (!bus.ready_o && waits < 50) begin waits++; @(negedge clk); end
    if (!bus.ready_o) begin
      n_chk++;
      $display("FAIL send_timeout: ready_o stayed 0 for %0d cycles, expected 1", waits);
    end else begin
      exp_q.push_back('{d: exp, t: tag});
    end
    step();
  endtask

  task automatic drain();
    int n = 0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    while ((exp_q.size() != 0 || bus.valid_o) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      n_chk++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
    end
    step();
  endtask

  task automatic lat_chk(input string nm, input logic [1:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [TW-1:0] tag, input logic [DW-1:0] exp);
    int w, n;
    send(op, a, b, tag, exp, w);
    bus.valid_i = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.valid_o && n < 20) begin @(negedge clk); n++; end
    chk({nm, "_latency"}, n, LAT - 1);
    @(negedge clk);
    chk({nm, "_valid_drop"}, bus.valid_o, 0);
    step();
  endtask

  vec_t vt[8];

  initial begin
    int w, acc, waits_sum;
    vt[0] = '{MUL,    32'h7,        32'hFFFFFFFD, 6'd5,  32'hFFFFFFEB};
    vt[1] = '{MULH,   32'h80000000, 32'h80000000, 6'd10, 32'h40000000};
    vt[2] = '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 6'd11, 32'hFFFFFFFE};
    vt[3] = '{MULHSU, 32'hFFFFFFFF, 32'h00000002, 6'd12, 32'hFFFFFFFF};
    vt[4] = '{MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 6'd13, 32'h00000001};
    vt[5] = '{MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 6'd14, 32'h00000000};
    vt[6] = '{MULHU,  32'h00010000, 32'h00010000, 6'd15, 32'h00000001};
    vt[7] = '{MULHSU, 32'h80000000, 32'hFFFFFFFF, 6'd16, 32'h80000000};

    rst = 1'b1; bus.flush = 1'b0; bus.valid_i = 1'b0; bus.ready_i = 1'b1;
    bus.op_i = MUL; bus.a_i = '0; bus.b_i = '0; bus.tag_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid_o", bus.valid_o, 0);
    chk("rst_data_o", bus.data_o, 0);
    chk("rst_tag_o", bus.tag_o, 0);
    chk("rst_ready_o", bus.ready_o, 1);
    step();

    // Single-op latency and post-result drop
    lat_chk("mul_basic", MUL, 32'h7, 32'hFFFFFFFD, 6'd5, 32'hFFFFFFEB);

    // Table vectors, one at a time
    foreach (vt[i]) begin
      send(vt[i].op, vt[i].a, vt[i].b, vt[i].tag, vt[i].exp, w);
      drain();
    end

    // Back-to-back MULs, tags 1..8
    pop_cyc.delete(); waits_sum = 0;
    for (int i = 1; i <= 8; i++) begin
      send(MUL, 32'(i * 3), 32'(i + 100), 6'(i), model(MUL, 32'(i * 3), 32'(i + 100)), w);
      waits_sum += w;
    end
    drain();
    chk("b2b_ready_waits", waits_sum, 0);
    chk("b2b_count", pop_cyc.size(), 8);
    if (pop_cyc.size() == 8) chk("b2b_consecutive", pop_cyc[7] - pop_cyc[0], 7);

    // Stream against a stalled consumer
    pops = 0; acc = 0;
    bus.ready_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.valid_i = 1'b1; bus.op_i = MULH;
      bus.a_i = 32'(-(acc + 5)); bus.b_i = 32'h40000000 + 32'(acc); bus.tag_i = 6'h20 + 6'(acc);
      @(negedge clk);
      if (bus.ready_o) begin
        exp_q.push_back('{d: model(MULH, bus.a_i, bus.b_i), t: bus.tag_i});
        acc++;
      end
      step();
    end
    chk("stall_accepts", acc, LAT);
    @(negedge clk);
    chk("stall_ready_low", bus.ready_o, 0);
    step();
    bus.ready_i = 1'b1;
    while (acc < 6) begin
      send(MULH, 32'(-(acc + 5)), 32'h40000000 + 32'(acc), 6'h20 + 6'(acc),
           model(MULH, 32'(-(acc + 5)), 32'h40000000 + 32'(acc)), w);
      acc++;
    end
    drain();
    chk("stall_pop_count", pops, 6);

    // Flush with two ops in flight and one presented
    send(MUL, 32'd9, 32'd9, 6'd40, 32'd81, w);
    send(MUL, 32'd8, 32'd8, 6'd41, 32'd64, w);
    pops = 0;
    bus.flush = 1'b1; bus.valid_i = 1'b1; bus.op_i = MUL; bus.a_i = 32'd2; bus.b_i = 32'd2; bus.tag_i = 6'd42;
    @(negedge clk);
    chk("flush_ready_o", bus.ready_o, 0);
    step();
    bus.flush = 1'b0; bus.valid_i = 1'b0;
    @(negedge clk);
    chk("flush_valid_o", bus.valid_o, 0);
    step();
    lat_chk("post_flush", MULHU, 32'hDEADBEEF, 32'h12345678, 6'd43, model(MULHU, 32'hDEADBEEF, 32'h12345678));
    drain();
    chk("flush_pop_count", pops, 1);

    // Reset with three ops in flight
    bus.ready_i = 1'b0;
    send(MUL, 32'd3, 32'd4, 6'd50, 32'd12, w);
    send(MUL, 32'd5, 32'd6, 6'd51, 32'd30, w);
    send(MUL, 32'd7, 32'd8, 6'd52, 32'd56, w);
    bus.valid_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid_o", bus.valid_o, 0);
    chk("midrst_data_o", bus.data_o, 0);
    chk("midrst_ready_o", bus.ready_o, 1);
    pops = 0;
    bus.ready_i = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_no_stale", pops, 0);
    step();

    // Random ops against random back-pressure
    begin
      logic done = 1'b0;
      fork
        begin
          for (int i = 0; i < 40; i++) begin
            logic [1:0] op; logic [DW-1:0] a, b;
            op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
            send(op, a, b, 6'(i), model(op, a, b), w);
            if ($urandom_range(0, 3) == 0) begin bus.valid_i = 1'b0; step(); end
          end
          bus.valid_i = 1'b0;
          done = 1'b1;
        end
        begin
          while (!done) begin
            bus.ready_i = 1'($urandom_range(0, 1));
            step();
          end
        end
      join
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/mdu_mul_pipe.md
MDU_MUL_PIPE -- requirements
Module: mdu_mul_pipe

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, operand and result width.
REQ-002 SHALL provide parameter TAG_W, default 6, width of the destination tag carried with each op.
REQ-003 SHALL provide parameter LAT, default 3, accept-to-result latency in cycles; legal range 2..6; elaboration SHALL fail outside this range.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 flush  in  1  kill all in-flight ops.
REQ-007 valid_i  in  1  request valid.
REQ-008 ready_o  out  1  request accepted when valid_i & ready_o.
REQ-009 op_i  in  2  0=MUL, 1=MULH, 2=MULHU, 3=MULHSU.
REQ-010 a_i, b_i  in  DATA_W each  operands (rs1, rs2).
REQ-011 tag_i  in  TAG_W  destination tag.
REQ-012 valid_o  out  1  result valid.
REQ-013 ready_i  in  1  consumer accepts result when valid_o & ready_i.
REQ-014 data_o  out  DATA_W  result.
REQ-015 tag_o  out  TAG_W  tag of the presented result.

Function
REQ-016 SHALL implement LAT stages S1..SLAT, each with its own valid bit, op, tag and data.
REQ-017 S1 SHALL register the operands sign-extended to DATA_W+1 bits; a_i sign-extended for MUL/MULH/MULHSU and zero-extended for MULHU; b_i sign-extended for MUL/MULH and zero-extended for MULHU/MULHSU.
REQ-018 S2 SHALL register the signed (DATA_W+1)x(DATA_W+1) product truncated to 2*DATA_W bits; S3..SLAT SHALL pass it through unchanged.
REQ-019 data_o SHALL equal product[DATA_W-1:0] for MUL and product[2*DATA_W-1:DATA_W] for MULH/MULHU/MULHSU.
REQ-020 Stage move chain: move_LAT = ready_i; move_k = ~v_(k+1) | move_(k+1); stage k SHALL load from stage k-1 only when move_k is true, so bubbles collapse.
REQ-021 ready_o SHALL equal (~v_1 | move_1) & ~flush & ~rst; ready_o SHALL be 1 whenever the pipeline is empty, independent of ready_i.
REQ-022 SHALL sustain one accept per cycle when ready_i stays high.
REQ-023 An op accepted at edge N SHALL have valid_o high in the cycle after edge N+LAT-1 when not stalled; each stall cycle adds exactly one cycle.
REQ-024 Results SHALL leave in acceptance order with no loss or duplication under any ready_i pattern.
REQ-025 While valid_o & ~ready_i, data_o, tag_o and valid_o SHALL hold stable.
REQ-026 flush SHALL clear every valid bit at the next edge; an op presented in the flush cycle SHALL NOT be accepted; a result presented in the flush cycle is discarded regardless of ready_i.
REQ-027 data_o and tag_o SHALL be driven to 0 whenever valid_o is 0.

Reset
REQ-028 rst SHALL clear all valid bits at the next edge; after reset valid_o=0, data_o=0, tag_o=0, ready_o=1.
REQ-029 Datapath registers SHALL NOT require reset.
REQ-030 rst asserted mid-operation SHALL discard all in-flight ops; none SHALL appear after reset.

Verification (DATA_W=32, LAT=3)
REQ-031 MUL a=7, b=0xFFFFFFFD, tag=5, ready_i=1 -> valid_o high 3 cycles after accept, data_o=0xFFFFFFEB, tag_o=5, then valid_o=0.
REQ-032 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF; MUL 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001.
REQ-033 Back-to-back MULs tags 1..8, ready_i=1 -> ready_o constantly 1; results on 8 consecutive cycles, tags 1..8 in order.
REQ-034 Continuous stream while ready_i=0 for 6 cycles -> ready_o falls after 3 accepts, outputs held stable; on ready_i=1, all ops emerge in order, none lost or duplicated.
REQ-035 Two ops in flight plus valid_i in the flush cycle -> next cycle valid_o=0 and neither in-flight op nor flush-cycle op emerges; an op accepted the cycle after flush returns after 3 cycles.
REQ-036 rst asserted with 3 ops in flight -> valid_o=0, data_o=0, ready_o=1 next cycle; no stale result emerges afterwards.
